// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester data-RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] LT_WORD = 2'b00;
    localparam logic [1:0] LT_HALF = 2'b01;
    localparam logic [1:0] LT_BYTE = 2'b10;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between fetch (0) and load/store (1).
// RAM_ARB_FIXED_PRIO_EN: load/store always wins a tie; otherwise round-robin on last.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic               valid,
    output logic               winner
);

    always_comb begin
        valid = |req;
`ifdef RAM_ARB_FIXED_PRIO_EN
        winner = req[1];
`else
        // On a tie the requester that was not granted last goes next.
        if (&req) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises fetch and load/store accesses onto the single-port data RAM.
// Tie-break policy selected by RAM_ARB_FIXED_PRIO_EN (see ram_arb_pick).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [1:0]            load_type_0,
    input  logic [1:0]            load_type_1,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic [1:0]            gnt,
    output logic [1:0]            ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_read_en,
    output logic                  ram_write_en,
    output logic [1:0]            ram_load_type,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    state_t                state_reg, state_next;
    logic                  owner_reg, owner_next;
    logic                  last_reg, last_next;
    logic                  we_reg, we_next;
    logic [1:0]            gnt_next, ack_next;
    logic [DATA_WIDTH-1:0] rdata_next;
    logic                  read_en_next, write_en_next;
    logic [1:0]            load_type_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] data_in_next;
    logic                  pick_valid, pick_winner;

    ram_arb_pick u_pick (
        .req    (req),
        .last   (last_reg),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;
        we_next        = we_reg;
        gnt_next       = '0;
        ack_next       = '0;
        rdata_next     = rdata;
        read_en_next   = 1'b0;
        write_en_next  = 1'b0;
        load_type_next = ram_load_type;
        addr_next      = ram_addr;
        data_in_next   = ram_data_in;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    owner_next              = pick_winner;
                    last_next               = pick_winner;
                    we_next                 = we[pick_winner];
                    load_type_next          = pick_winner ? load_type_1 : load_type_0;
                    addr_next               = pick_winner ? addr_1 : addr_0;
                    data_in_next            = pick_winner ? wdata_1 : wdata_0;
                    gnt_next[pick_winner]   = 1'b1;
                    // Enables are registered, so they go high together with gnt.
                    read_en_next            = ~we[pick_winner];
                    write_en_next           = we[pick_winner];
                    state_next              = ISSUE;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    ack_next[owner_reg] = 1'b1;
                    state_next          = IDLE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                rdata_next          = ram_data_out;
                ack_next[owner_reg] = 1'b1;
                state_next          = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            last_reg      <= 1'b1;
            we_reg        <= 1'b0;
            gnt           <= '0;
            ack           <= '0;
            rdata         <= '0;
            ram_read_en   <= 1'b0;
            ram_write_en  <= 1'b0;
            ram_load_type <= '0;
            ram_addr      <= '0;
            ram_data_in   <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            we_reg        <= we_next;
            gnt           <= gnt_next;
            ack           <= ack_next;
            rdata         <= rdata_next;
            ram_read_en   <= read_en_next;
            ram_write_en  <= write_en_next;
            ram_load_type <= load_type_next;
            ram_addr      <= addr_next;
            ram_data_in   <= data_in_next;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: behavioural RAM, transaction-level predictor, monitor.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [1:0]  lt0, lt1;
    logic [31:0] a0, a1, wd0, wd1;
    logic [1:0]  req, we;
    logic [1:0]  gnt, ack, ram_load_type;
    logic [31:0] rdata, ram_addr, ram_data_in, ram_data_out;
    logic        ram_read_en, ram_write_en;
    logic        mem_clr;

    assign req = {req1, req0};
    assign we  = {we1, we0};

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .load_type_0(lt0), .load_type_1(lt1),
        .addr_0(a0), .addr_1(a1), .wdata_0(wd0), .wdata_1(wd1),
        .gnt(gnt), .ack(ack), .rdata(rdata),
        .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
        .ram_load_type(ram_load_type), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] lt);
        case (lt)
            2'b00:   return w;
            2'b01:   return {{16{w[15]}}, w[15:0]};
            2'b10:   return {{24{w[7]}}, w[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Behavioural RAM: registered read and write, word-addressed, 32 words.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
        end else begin
            if (ram_write_en) mem[ram_addr[4:0]] <= ram_data_in;
            if (ram_read_en)  ram_data_out <= load_val(mem[ram_addr[4:0]], ram_load_type);
        end
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          id;
        bit          wr;
        logic [1:0]  lt;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        gnt_q[$];
    exp_t        ack_q[$];
    int          gnt_log[$];
    logic [31:0] last_rdata;

    // Predictor: the arbiter is free again in the cycle the previous ack is visible.
    logic [31:0] ref_mem [32];
    int          m_free;
    int          m_last;
    int          m_win;
    exp_t        pe;
    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        m_free = 0;
        m_last = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                gnt_q.delete();
                ack_q.delete();
                m_free = 0;
                m_last = 1;
            end else if (cyc >= m_free && (req0 || req1)) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                m_win = req1 ? 1 : 0;
`else
                if (req0 && req1) m_win = (m_last == 1) ? 0 : 1;
                else              m_win = req1 ? 1 : 0;
`endif
                pe.id   = m_win;
                pe.wr   = (m_win == 1) ? we1 : we0;
                pe.lt   = (m_win == 1) ? lt1 : lt0;
                pe.addr = (m_win == 1) ? a1 : a0;
                pe.data = (m_win == 1) ? wd1 : wd0;
                pe.cyc  = cyc + 1;
                gnt_q.push_back(pe);
                if (pe.wr) begin
                    ref_mem[pe.addr[4:0]] = pe.data;
                    pe.cyc = cyc + 2;
                end else begin
                    pe.data = load_val(ref_mem[pe.addr[4:0]], pe.lt);
                    pe.cyc = cyc + 3;
                end
                ack_q.push_back(pe);
                m_free = pe.cyc;
                m_last = m_win;
            end
        end
    end

    // Monitor: compares every gnt/ack the DUT presents against the queues.
    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gnt != 2'b00) begin
                    gnt_log.push_back(gnt[1] ? 1 : 0);
                    if (gnt_q.size() == 0) begin
                        chk("gnt_unexpected", 32'(gnt), 32'h0);
                    end else begin
                        me = gnt_q.pop_front();
                        chk("gnt_id", 32'(gnt), 32'(1 << me.id));
                        chk("gnt_cycle", 32'(cyc), 32'(me.cyc));
                        chk("ram_addr", ram_addr, me.addr);
                        chk("ram_read_en", 32'(ram_read_en), 32'(!me.wr));
                        chk("ram_write_en", 32'(ram_write_en), 32'(me.wr));
                        if (me.wr) chk("ram_data_in", ram_data_in, me.data);
                        else       chk("ram_load_type", 32'(ram_load_type), 32'(me.lt));
                    end
                end else begin
                    chk("idle_enables", 32'({ram_read_en, ram_write_en}), 32'h0);
                    if (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc) begin
                        me = gnt_q.pop_front();
                        chk("gnt_missing", 32'(gnt), 32'(1 << me.id));
                    end
                end
                if (ack != 2'b00) begin
                    last_rdata = rdata;
                    if (ack_q.size() == 0) begin
                        chk("ack_unexpected", 32'(ack), 32'h0);
                    end else begin
                        me = ack_q.pop_front();
                        chk("ack_id", 32'(ack), 32'(1 << me.id));
                        chk("ack_cycle", 32'(cyc), 32'(me.cyc));
                        if (!me.wr) chk("rdata", rdata, me.data);
                    end
                end else if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
                    me = ack_q.pop_front();
                    chk("ack_missing", 32'(ack), 32'(1 << me.id));
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raises one request and holds it until its gnt is seen.
    task automatic issue(input int r, input logic w, input logic [1:0] lt,
                         input logic [31:0] a, input logic [31:0] d);
        bit seen = 1'b0;
        if (r == 0) begin req0 = 1'b1; we0 = w; lt0 = lt; a0 = a; wd0 = d; end
        else        begin req1 = 1'b1; we1 = w; lt1 = lt; a1 = a; wd1 = d; end
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (gnt[r]) seen = 1'b1;
        end
        if (r == 0) req0 = 1'b0;
        else        req1 = 1'b0;
        if (!seen) chk("gnt_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (gnt_q.size() + ack_q.size()) > 0; i++) wait_cycles(1);
        wait_cycles(1);
        chk("drain", 32'(gnt_q.size() + ack_q.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          base;
    int          pat [6];
    logic [1:0]  lts [4];
    logic [31:0] lexp [4];
    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lt0 = 0; lt1 = 0;
        a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;
        wait_cycles(3);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_en", 32'({ram_read_en, ram_write_en}), 32'h0);
        chk("rst_lt", 32'(ram_load_type), 32'h0);
        chk("rst_addr", ram_addr, 32'h0);
        chk("rst_din", ram_data_in, 32'h0);
        mem_clr = 1'b0;
        rst = 1'b0;

        issue(1, 1'b1, LT_WORD, 32'd5, 32'hDEADBEEF);
        issue(0, 1'b0, LT_WORD, 32'd5, 32'h0);
        drain();
        chk("read_deadbeef", last_rdata, 32'hDEADBEEF);

        issue(1, 1'b1, LT_WORD, 32'd3, 32'h12345678);
        issue(0, 1'b0, LT_WORD, 32'd3, 32'h0);
        drain();
        chk("write_readback", last_rdata, 32'h12345678);

        lts[0] = LT_HALF; lts[1] = LT_BYTE; lts[2] = 2'b11; lts[3] = LT_WORD;
        lexp[0] = 32'hFFFF80F0; lexp[1] = 32'hFFFFFFF0; lexp[2] = 32'h0; lexp[3] = 32'h000080F0;
        issue(1, 1'b1, LT_WORD, 32'd7, 32'h000080F0);
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b0, lts[i], 32'd7, 32'h0);
            drain();
            chk("load_type_result", last_rdata, lexp[i]);
        end

        // Requester 1 goes last so the first contended grant belongs to requester 0.
        issue(1, 1'b0, LT_WORD, 32'd9, 32'h0);
        drain();
        base = gnt_log.size();
`ifdef RAM_ARB_FIXED_PRIO_EN
        pat = '{1, 1, 1, 0, 0, 0};
`else
        pat = '{0, 1, 0, 1, 0, 1};
`endif
        fork
            repeat (3) issue(0, 1'b0, LT_WORD, 32'($urandom_range(0, 31)), 32'h0);
            repeat (3) issue(1, 1'b0, LT_WORD, 32'($urandom_range(0, 31)), 32'h0);
        join
        drain();
        chk("contention_count", 32'(gnt_log.size() - base), 32'd6);
        for (int i = 0; i < 6 && base + i < gnt_log.size(); i++)
            chk("contention_order", 32'(gnt_log[base + i]), 32'(pat[i]));

        fork
            for (int k = 0; k < 25; k++) begin
                wait_cycles($urandom_range(0, 3));
                issue(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      32'($urandom_range(0, 31)), $urandom);
            end
            for (int k = 0; k < 25; k++) begin
                wait_cycles($urandom_range(0, 3));
                issue(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      32'($urandom_range(0, 31)), $urandom);
            end
        join
        drain();

        // Abort a read while it is in ISSUE.
        issue(0, 1'b0, LT_WORD, 32'd5, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_gnt", 32'(gnt), 32'h0);
        chk("abort_en", 32'({ram_read_en, ram_write_en}), 32'h0);
        chk("abort_addr", ram_addr, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_state", 32'(dut.state_reg), 32'(IDLE));
        wait_cycles(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cycles(1);
            chk("abort_no_ack", 32'(ack), 32'h0);
        end

        base = gnt_log.size();
        fork
            issue(0, 1'b0, LT_WORD, 32'd5, 32'h0);
            issue(1, 1'b0, LT_WORD, 32'd3, 32'h0);
        join
        drain();
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk("post_reset_tie", 32'(gnt_log[base]), 32'd1);
`else
        chk("post_reset_tie", 32'(gnt_log[base]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
